uart_word_reader: RTL and testbench
===================================

UART_WORD_READER -- requirements
Module: uart_word_reader

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4, meaning bytes per assembled word (2..8).
REQ-002 SHALL have parameter BIG_ENDIAN, default 0, meaning 0 = first byte lands in bits [7:0], 1 = first byte lands in the MSB.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 32'd1000000, meaning the idle cycles allowed between bytes of one word.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port uart_out_ready  input  1  UART controller has a received byte available.
REQ-007 SHALL have port uart_out_data  input  8  head byte; valid whenever uart_out_ready=1.
REQ-008 SHALL have port uart_out_valid  output  1  pop strobe; consumes the head byte in the same cycle.
REQ-009 SHALL have port word_data  output  8*WORD_BYTES  assembled word.
REQ-010 SHALL have port word_valid  output  1  word_data holds a complete word.
REQ-011 SHALL have port word_ready  input  1  sink accepts the word.
REQ-012 SHALL have port byte_count  output  $clog2(WORD_BYTES+1)  bytes collected for the current word.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse when a partial word is discarded.

Function
REQ-014 SHALL implement two states: COLLECT and HOLD.
REQ-015 In COLLECT, SHALL drive uart_out_valid=uart_out_ready combinationally and capture uart_out_data on that edge into byte lane byte_count (reversed when BIG_ENDIAN=1), then increment byte_count.
REQ-016 SHALL move COLLECT->HOLD on the edge that captures byte WORD_BYTES-1, and SHALL assert word_valid from the next cycle.
REQ-017 In HOLD, SHALL hold uart_out_valid=0 regardless of uart_out_ready (backpressure), and SHALL keep word_data stable.
REQ-018 In HOLD, SHALL transition to COLLECT and clear byte_count on the edge where word_ready=1; one bubble cycle SHALL follow before the next pop.
REQ-019 SHALL keep word_valid=0 in COLLECT; word_ready SHALL be ignored in COLLECT.
REQ-020 SHALL capture no byte and take no action when uart_out_ready=0.
REQ-021 SHALL keep byte_count saturated at WORD_BYTES while in HOLD.

Reset
REQ-022 On reset=1 at a clock edge, SHALL enter COLLECT with byte_count=0, word_valid=0, word_data=0, timeout=0, and the timeout counter=0.
REQ-023 SHALL drive uart_out_valid=0 during any cycle with reset=1.
REQ-024 Reset in the middle of a word SHALL discard the partial word and pop no byte in that cycle.

Configuration
REQ-025 Macro UART_WORD_READER_TIMEOUT_EN SHALL gate the inter-byte timeout.
REQ-026 When the macro is defined, in COLLECT with byte_count>0, a 32-bit counter SHALL clear on each capture and increment otherwise.
REQ-027 When the macro is defined and the counter reaches TIMEOUT_CYCLES-1 with no capture in that cycle, SHALL clear byte_count and the counter and pulse timeout for one cycle.
REQ-028 When the macro is defined and a capture coincides with expiry, the capture SHALL win and no timeout SHALL occur.
REQ-029 When the macro is defined, the counter SHALL be idle in HOLD.
REQ-030 When the macro is undefined, the timeout port SHALL exist tied to 0 and partial words SHALL persist indefinitely.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum (COLLECT, HOLD) and the timeout counter width constant (32).
REQ-032 Byte-lane placement (lane index, endianness swap) SHALL be a sub-module uart_byte_lane_mux; all other logic SHALL be inline.

Verification
REQ-033 Bench SHALL cover little-endian assembly: BIG_ENDIAN=0, bytes 0x78,0x56,0x34,0x12 back-to-back -> exactly 4 pops, word_data=0x12345678, word_valid=1 the cycle after the 4th pop.
REQ-034 Bench SHALL cover big-endian assembly: BIG_ENDIAN=1, same bytes -> word_data=0x78563412.
REQ-035 Bench SHALL cover backpressure: word_valid=1, word_ready=0 for 10 cycles, uart_out_ready=1 -> uart_out_valid=0 all 10 cycles and word_data unchanged; word_ready=1 -> 1 bubble cycle, then pops resume.
REQ-036 Bench SHALL cover reset mid-word: 2 bytes, reset 1 cycle, then 0xAA,0xBB,0xCC,0xDD -> word_data=0xDDCCBBAA, no timeout.
REQ-037 Bench SHALL cover timeout with the macro defined: TIMEOUT_CYCLES=16, 2 bytes then silence -> timeout pulse on the 16th idle cycle, byte_count=0, and the next 4 bytes form a clean word.
REQ-038 Bench SHALL cover streaming: 64 random bytes with random word_ready -> 16 words in order, no byte lost or duplicated.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word reader.
package uart_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam int TO_CNT_W = 32;

endpackage

// File: rtl/uart_byte_lane_mux.sv
// Writes one received byte into its lane of the word being assembled.
// BIG_ENDIAN=1 mirrors the lane order so the first byte lands in the MSB.
module uart_byte_lane_mux #(
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 0,
  parameter int CW         = 3
) (
  input  logic [8*WORD_BYTES-1:0] word_i,
  input  logic [CW-1:0]           lane_i,
  input  logic [7:0]              byte_i,
  input  logic                    wr_i,
  output logic [8*WORD_BYTES-1:0] word_o
);

  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    localparam int PHYS = (BIG_ENDIAN != 0) ? (WORD_BYTES - 1 - gi) : gi;
    assign word_o[8*PHYS +: 8] = (wr_i && (lane_i == CW'(gi))) ? byte_i
                                                              : word_i[8*PHYS +: 8];
  end

endmodule

// File: rtl/uart_word_reader.sv
// Pops bytes from a UART receive buffer and assembles WORD_BYTES-byte words.
// Define UART_WORD_READER_TIMEOUT_EN to discard partial words after an idle gap.
module uart_word_reader
  import uart_pkg::*;
#(
  parameter int          WORD_BYTES     = 4,
  parameter int          BIG_ENDIAN     = 0,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               uart_out_ready,
  input  logic [7:0]                         uart_out_data,
  output logic                               uart_out_valid,
  output logic [8*WORD_BYTES-1:0]            word_data,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic [$clog2(WORD_BYTES+1)-1:0]    byte_count,
  output logic                               timeout
);

  localparam int            CW   = $clog2(WORD_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic                    pop;
  logic                    expire;

  // Reset suppresses the pop so a byte is never lost while the word is discarded.
  assign pop = (state_q == COLLECT) && uart_out_ready && !reset;

  uart_byte_lane_mux #(
    .WORD_BYTES (WORD_BYTES),
    .BIG_ENDIAN (BIG_ENDIAN),
    .CW         (CW)
  ) u_lane_mux (
    .word_i (word_q),
    .lane_i (count_q),
    .byte_i (uart_out_data),
    .wr_i   (pop),
    .word_o (word_d)
  );

`ifdef UART_WORD_READER_TIMEOUT_EN
  logic [TO_CNT_W-1:0] idle_q, idle_d;

  // A capture in the expiry cycle wins: pop is tested before the limit.
  always_comb begin
    idle_d = idle_q;
    expire = 1'b0;
    if (state_q == COLLECT && count_q != '0) begin
      if (pop) begin
        idle_d = '0;
      end else if (idle_q == TIMEOUT_CYCLES - 32'd1) begin
        idle_d = '0;
        expire = 1'b1;
      end else begin
        idle_d = idle_q + TO_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  // Partial words persist; the limit is still referenced so both builds share one parameter set.
  assign expire = (TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      COLLECT: begin
        if (pop) begin
          count_d = count_q + CW'(1);
          if (count_q == LAST) begin
            state_d = HOLD;
          end
        end else if (expire) begin
          count_d = '0;
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      default: begin
        state_d = COLLECT;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  assign uart_out_valid = pop;
  assign word_valid     = (state_q == HOLD);
  assign word_data      = word_q;
  assign byte_count     = count_q;
  assign timeout        = expire && !reset;

endmodule

// File: tb/tb_uart_word_reader.sv
// Directed bench for uart_word_reader: little/big-endian instances share stimulus.
module tb_uart_word_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_out_ready;
  logic [7:0]  uart_out_data;
  logic        word_ready;

  logic        le_pop, le_wv, le_to;
  logic [31:0] le_word;
  logic [2:0]  le_bc;
  logic        be_pop, be_wv, be_to;
  logic [31:0] be_word;
  logic [2:0]  be_bc;

  always #5 clk = ~clk;

  uart_word_reader #(.WORD_BYTES(4), .BIG_ENDIAN(0), .TIMEOUT_CYCLES(32'd16)) dut_le (
    .clk(clk), .reset(reset), .uart_out_ready(uart_out_ready), .uart_out_data(uart_out_data),
    .uart_out_valid(le_pop), .word_data(le_word), .word_valid(le_wv), .word_ready(word_ready),
    .byte_count(le_bc), .timeout(le_to)
  );

  uart_word_reader #(.WORD_BYTES(4), .BIG_ENDIAN(1), .TIMEOUT_CYCLES(32'd16)) dut_be (
    .clk(clk), .reset(reset), .uart_out_ready(uart_out_ready), .uart_out_data(uart_out_data),
    .uart_out_valid(be_pop), .word_data(be_word), .word_valid(be_wv), .word_ready(word_ready),
    .byte_count(be_bc), .timeout(be_to)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_le;
    logic [31:0] exp_be;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  fifo[$];
  bit          src_en = 1'b1;
  bit          last_pop, last_to, acc;
  logic [31:0] acc_word;
  int          tmo_hits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: present the FIFO head, sample outputs, apply the edge, retire a popped byte.
  task automatic tick();
    uart_out_ready = src_en && (fifo.size() != 0);
    uart_out_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
    last_pop = le_pop;
    last_to  = le_to;
    if (le_to) tmo_hits++;
    acc      = le_wv && word_ready;
    acc_word = le_word;
    @(posedge clk);
    if (last_pop) void'(fifo.pop_front());
    #1;
  endtask

  task automatic release_word();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  vec_t        vecs[4];
  logic [7:0]  sent[$];
  logic [31:0] exp_w;
  int          pops, idle_k, words, budget;

  initial begin
    vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678, 32'h78563412};
    vecs[1] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCCBBAA, 32'hAABBCCDD};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 8'h80, 32'h8001FF00, 32'h00FF0180};
    vecs[3] = '{8'h5A, 8'hA5, 8'hC3, 8'h3C, 32'h3CC3A55A, 32'h5AA5C33C};

    reset = 1'b1; word_ready = 1'b0; uart_out_ready = 1'b0; uart_out_data = 8'h00;
    fifo.push_back(8'h99);
    tick();
    tick();
    check("pop_during_reset", last_pop, 1'b0);
    reset = 1'b0;
    fifo.delete();
    tick();
    check("reset_byte_count", le_bc, 3'd0);
    check("reset_word_valid", le_wv, 1'b0);
    check("reset_word_data", le_word, 32'h0);
    check("reset_timeout", last_to, 1'b0);
    $display("reset: byte_count=%0d word_valid=%0b", le_bc, le_wv);

    // Table: back-to-back words in both byte orders.
    for (int v = 0; v < 4; v++) begin
      fifo.push_back(vecs[v].b0); fifo.push_back(vecs[v].b1);
      fifo.push_back(vecs[v].b2); fifo.push_back(vecs[v].b3);
      pops = 0;
      for (int i = 0; i < 3; i++) begin tick(); if (last_pop) pops++; end
      check("mid_word_valid", le_wv, 1'b0);
      check("mid_byte_count", le_bc, 3'd3);
      tick(); if (last_pop) pops++;
      check("pop_count", pops, 4);
      check("word_valid_after_4th", le_wv, 1'b1);
      check("le_word", le_word, vecs[v].exp_le);
      check("be_word", be_word, vecs[v].exp_be);
      check("hold_byte_count", le_bc, 3'd4);
      $display("vec %0d: le=%h be=%h", v, le_word, be_word);
      release_word();
      check("release_valid", le_wv, 1'b0);
      check("release_byte_count", le_bc, 3'd0);
    end

    // Backpressure: HOLD must not pop while the sink stalls.
    fifo = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_no_pop", last_pop, 1'b0);
      check("bp_word_stable", le_word, 32'h44332211);
    end
    word_ready = 1'b1;
    tick();
    check("bp_bubble", last_pop, 1'b0);
    word_ready = 1'b0;
    tick();
    check("bp_resume", last_pop, 1'b1);
    repeat (3) tick();
    check("bp_second_valid", le_wv, 1'b1);
    check("bp_second_word", le_word, 32'h88776655);
    $display("backpressure: second word=%h", le_word);
    release_word();

    // Reset in the middle of a word.
    fifo = '{8'h01, 8'h02};
    tmo_hits = 0;
    repeat (2) tick();
    check("rst_mid_count", le_bc, 3'd2);
    fifo = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    reset = 1'b1;
    tick();
    check("rst_mid_no_pop", last_pop, 1'b0);
    reset = 1'b0;
    check("rst_mid_cleared", le_bc, 3'd0);
    repeat (4) tick();
    check("rst_mid_word", le_word, 32'hDDCCBBAA);
    check("rst_mid_valid", le_wv, 1'b1);
    check("rst_mid_no_timeout", tmo_hits, 0);
    $display("reset mid-word: word=%h", le_word);
    release_word();

    // Inter-byte idle gap.
    fifo = '{8'h01, 8'h02};
    tmo_hits = 0;
    idle_k = 0;
    repeat (2) tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (last_to && idle_k == 0) idle_k = k;
    end
`ifdef UART_WORD_READER_TIMEOUT_EN
    check("timeout_cycle", idle_k, 16);
    check("timeout_pulses", tmo_hits, 1);
    check("timeout_count_cleared", le_bc, 3'd0);
    fifo = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    repeat (4) tick();
    check("timeout_clean_word", le_word, 32'hD4C3B2A1);
`else
    check("no_timeout_pulses", tmo_hits, 0);
    check("partial_persists", le_bc, 3'd2);
    fifo = '{8'h03, 8'h04};
    repeat (2) tick();
    check("partial_completes", le_word, 32'h04030201);
`endif
    check("gap_word_valid", le_wv, 1'b1);
    $display("idle gap: timeout at idle cycle %0d, word=%h", idle_k, le_word);
    release_word();

    // Streaming with random source gaps and random sink readiness.
    sent.delete();
    for (int i = 0; i < 64; i++) begin
      sent.push_back(8'($urandom_range(0, 255)));
      fifo.push_back(sent[i]);
    end
    words = 0;
    budget = 0;
    while (words < 16 && budget < 3000) begin
      src_en = ($urandom_range(0, 3) != 0);
      word_ready = ($urandom_range(0, 1) != 0);
      tick();
      budget++;
      if (acc) begin
        exp_w = {sent[4*words+3], sent[4*words+2], sent[4*words+1], sent[4*words]};
        check("stream_word", acc_word, exp_w);
        $display("stream word %0d = %h", words, acc_word);
        words++;
      end
    end
    src_en = 1'b1;
    word_ready = 1'b0;
    check("stream_word_count", words, 16);
    check("stream_fifo_drained", fifo.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
